// File: rtl/sw_debounce.sv
// Two-flop synchronizer plus per-bit stability filter for board slide switches,
// with registered rise/fall pulses. Define SW_DEBOUNCE_EN to build the counter filter.
module sw_debounce #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             any_change
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, fall_q;
    logic             any_q;
    logic [WIDTH-1:0] accept;

`ifdef SW_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // A bit is accepted on the cycle its mismatch run reaches DEBOUNCE_CYCLES;
    // any matching cycle or an acceptance restarts its count from zero.
    always_comb begin
        accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accept[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the counters are individual flops, not a RAM, so they take the
        // reset like any other state; partial counts must not survive reset.
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    // Unfiltered build: every synchronized change is accepted immediately.
    logic unused_cfg;
    assign unused_cfg = ^{DEBOUNCE_CYCLES, CNT_W};
    assign accept     = sync2_q ^ stable_q;
`endif

    assign stable_d = stable_q ^ accept;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so sync2_q samples the old sync1_q and
        // the pulses see the pre-edge sync2_q, giving a true two-flop pipeline.
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            any_q    <= 1'b0;
        end else begin
            sync1_q  <= sw_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            rise_q   <= accept & sync2_q;
            fall_q   <= accept & ~sync2_q;
            any_q    <= |accept;
        end
    end

    assign switches   = stable_q;
    assign sw_rise    = rise_q;
    assign sw_fall    = fall_q;
    assign any_change = any_q;

endmodule
